// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU latencies,
// the "operand not used" Tuse code, the MDU FSM states and the hazard compare.
package hazard_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE    = 2'd3;
   localparam int         MULT_LAT_DEF = 5;
   localparam int         DIV_LAT_DEF  = 10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   // A source register collides with a producer when the producer writes it and
   // the result arrives later than the consumer needs it; TUSE_NONE never collides.
   function automatic logic src_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] wa,
                                       input logic [1:0] tnew);
      return (src == wa) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Multi-cycle mult/div busy tracker: IDLE/BUSY FSM with a reload countdown
// and a sticky error flag for starts issued while the unit is still busy.
module md_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic err
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] load;

   assign load = is_div ? DIV_LOAD : MULT_LOAD;
   assign busy = start | (state == BUSY);

   // The start cycle itself is the first busy cycle, so a latency-1 operation
   // never leaves IDLE; the last BUSY cycle is the one where cnt drops to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (load != '0)) begin
                  state <= BUSY;
                  cnt   <= load;
               end
            end
            BUSY: begin
               if (start)
                  err <= 1'b1;
               if (cnt <= CNT_ONE) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: combines Tuse/Tnew register
// hazards with MDU occupancy and counts stalled cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic        d_is_md,
   input  logic [4:0]  e_wa,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_wa,
   input  logic [1:0]  m_tnew,
   input  logic        e_md_start,
   input  logic        e_md_div,
   output logic        stall,
   output logic        flush_e,
   output logic        md_busy,
   output logic        md_err,
   output logic [31:0] stall_cnt
);

   logic stall_rs;
   logic stall_rt;

   md_timer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (e_md_start),
      .is_div (e_md_div),
      .busy   (md_busy),
      .err    (md_err)
   );

   // $0 is hard-wired zero, so it can never carry a pending result.
   assign stall_rs = (d_rs != 5'd0) &&
                     (src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew) ||
                      src_hazard(d_rs, d_tuse_rs, m_wa, m_tnew));
   assign stall_rt = (d_rt != 5'd0) &&
                     (src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew) ||
                      src_hazard(d_rt, d_tuse_rt, m_wa, m_tnew));

   assign stall   = stall_rs | stall_rt | (d_is_md & md_busy);
   assign flush_e = stall;

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall)
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: register hazards, MDU busy
// windows, sticky error, reset mid-countdown and the stall counter.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, e_wa, m_wa;
   logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic        d_is_md, e_md_start, e_md_div;
   logic        stall, flush_e, md_busy, md_err;
   logic [31:0] stall_cnt;

   int compared   = 0;
   int mismatched = 0;
   int n_stall;

   hazard_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_is_md    (d_is_md),
      .e_wa       (e_wa),
      .e_tnew     (e_tnew),
      .m_wa       (m_wa),
      .m_tnew     (m_tnew),
      .e_md_start (e_md_start),
      .e_md_div   (e_md_div),
      .stall      (stall),
      .flush_e    (flush_e),
      .md_busy    (md_busy),
      .md_err     (md_err),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic idle_inputs();
      d_rs = 5'd0; d_rt = 5'd0;
      d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
      d_is_md = 1'b0;
      e_wa = 5'd0; e_tnew = 2'd0;
      m_wa = 5'd0; m_tnew = 2'd0;
      e_md_start = 1'b0; e_md_div = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;

      // Reset held two cycles with random inputs
      for (int i = 0; i < 2; i++) begin
         d_rs = 5'($urandom); d_rt = 5'($urandom);
         d_tuse_rs = 2'($urandom); d_tuse_rt = 2'($urandom);
         d_is_md = 1'($urandom);
         e_wa = 5'($urandom); e_tnew = 2'($urandom);
         m_wa = 5'($urandom); m_tnew = 2'($urandom);
         e_md_start = 1'($urandom); e_md_div = 1'($urandom);
         tick();
      end
      idle_inputs();
      #1;
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_md_busy", 32'(md_busy), 32'd0);
      check("rst_md_err", 32'(md_err), 32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_stall", 32'(stall), 32'd0);
      check("post_rst_cnt", stall_cnt, 32'd0);

      // Register hazards
      d_rs = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd1;
      #1;
      check("rs_e_stall", 32'(stall), 32'd1);
      check("rs_e_flush", 32'(flush_e), 32'd1);
      tick();
      check("cnt_after_rs", stall_cnt, 32'd1);
      d_rs = 5'd0;
      #1;
      check("r0_no_stall", 32'(stall), 32'd0);
      d_rs = 5'd5; e_wa = 5'd0; m_wa = 5'd5; m_tnew = 2'd0;
      #1;
      check("rs_m_tnew0", 32'(stall), 32'd0);
      m_tnew = 2'd1;
      #1;
      check("rs_m_tnew1", 32'(stall), 32'd1);
      idle_inputs();
      d_rt = 5'd7; d_tuse_rt = 2'd1; e_wa = 5'd7; e_tnew = 2'd2;
      #1;
      check("rt_e_stall", 32'(stall), 32'd1);
      d_tuse_rt = 2'd2;
      #1;
      check("rt_e_equal", 32'(stall), 32'd0);
      idle_inputs();
      tick();
      check("cnt_hold", stall_cnt, 32'd1);

      // Mult: busy and stalled for exactly 5 cycles
      e_md_start = 1'b1; e_md_div = 1'b0; d_is_md = 1'b1;
      #1;
      check("mult_busy_T0", 32'(md_busy), 32'd1);
      check("mult_stall_T0", 32'(stall), 32'd1);
      tick();
      e_md_start = 1'b0;
      for (int i = 1; i < 5; i++) begin
         #1;
         check($sformatf("mult_busy_T%0d", i), 32'(md_busy), 32'd1);
         check($sformatf("mult_stall_T%0d", i), 32'(stall), 32'd1);
         tick();
      end
      check("mult_busy_T5", 32'(md_busy), 32'd0);
      check("mult_stall_T5", 32'(stall), 32'd0);
      check("mult_cnt", stall_cnt, 32'd6);
      check("mult_no_err", 32'(md_err), 32'd0);

      // Div: exactly 10 stall cycles within a 15-cycle window
      e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
      n_stall = 0;
      for (int i = 0; i < 15; i++) begin
         #1;
         if (stall) n_stall++;
         tick();
         e_md_start = 1'b0;
      end
      check("div_stall_cycles", 32'(n_stall), 32'd10);
      check("div_cnt", stall_cnt, 32'd16);

      // Non-MD instruction in D while MDU busy does not stall
      d_is_md = 1'b0;
      e_md_start = 1'b1; e_md_div = 1'b0;
      tick();
      e_md_start = 1'b0;
      #1;
      check("nonmd_busy", 32'(md_busy), 32'd1);
      check("nonmd_stall", 32'(stall), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("nonmd_done", 32'(md_busy), 32'd0);
      check("nonmd_cnt", stall_cnt, 32'd16);

      // Second start while busy: sticky error, countdown not reloaded
      e_md_start = 1'b1; e_md_div = 1'b0;
      tick();
      e_md_start = 1'b0;
      tick();
      e_md_start = 1'b1; e_md_div = 1'b1;
      #1;
      check("err_before_edge", 32'(md_err), 32'd0);
      tick();
      e_md_start = 1'b0;
      #1;
      check("err_set_T3", 32'(md_err), 32'd1);
      check("err_busy_T3", 32'(md_busy), 32'd1);
      tick();
      check("err_busy_T4", 32'(md_busy), 32'd1);
      tick();
      check("err_busy_T5", 32'(md_busy), 32'd0);
      check("err_sticky_T5", 32'(md_err), 32'd1);
      tick();
      check("err_sticky_T6", 32'(md_err), 32'd1);

      // Reset in the middle of a countdown
      e_md_start = 1'b1; e_md_div = 1'b1;
      tick();
      e_md_start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_mid_busy", 32'(md_busy), 32'd0);
      check("rst_mid_err", 32'(md_err), 32'd0);
      check("rst_mid_cnt", stall_cnt, 32'd0);
      tick();
      check("rst_mid_busy2", 32'(md_busy), 32'd0);

      // Register hazard overlapping MDU busy counts once per cycle
      d_rt = 5'd9; d_tuse_rt = 2'd1; e_wa = 5'd9; e_tnew = 2'd2;
      d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("overlap_stall_%0d", i), 32'(stall), 32'd1);
         tick();
         e_md_start = 1'b0;
      end
      check("overlap_cnt", stall_cnt, 32'd5);
      check("overlap_idle_busy", 32'(md_busy), 32'd0);
      check("overlap_rt_only", 32'(stall), 32'd1);
      idle_inputs();
      #1;
      check("overlap_clear", 32'(stall), 32'd0);
      tick();
      check("overlap_cnt_final", stall_cnt, 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
